// File: rtl/fifo_rdarbiter.sv
// fifo_rdarbiter: round-robin bursting read scheduler draining per-channel FIFOs into one tagged ready/valid stream.
// Define FIFO_RDARBITER_STRICT_PRIORITY_EN to replace round-robin with lowest-index-first selection.
module fifo_rdarbiter #(
    parameter int CHANNEL_WIDTH = 32,
    parameter int CHANNELS_CNT  = 3,
    parameter int BURST_MAX     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CHANNELS_CNT-1:0]                i_en_channels,
    input  logic [CHANNELS_CNT-1:0]                i_empty_channels,
    output logic [CHANNELS_CNT-1:0]                o_rd_en_channels,
    input  logic [CHANNELS_CNT-1:0]                i_rd_valid_channels,
    input  logic [CHANNELS_CNT*CHANNEL_WIDTH-1:0]  i_rd_data_channels,
    output logic                                   o_valid,
    output logic [CHANNEL_WIDTH-1:0]               o_data,
    output logic [$clog2(CHANNELS_CNT)-1:0]        o_channel,
    input  logic                                   i_ready,
    output logic                                   o_busy,
    output logic                                   o_err_unexpected
);
    localparam int TW = $clog2(CHANNELS_CNT);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [CHANNELS_CNT-1:0] ONE = CHANNELS_CNT'(1);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
    localparam logic [TW-1:0] LAST = TW'(CHANNELS_CNT - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           grant_q, grant_d;
    logic [BW-1:0]           burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]           rr_ptr_q, rr_ptr_d;
    logic                    inflight_q, inflight_d;
    logic [TW-1:0]           tag_q, tag_d;
    logic [CHANNEL_WIDTH-1:0] buf_data_q [2];
    logic [CHANNEL_WIDTH-1:0] buf_data_d [2];
    logic [TW-1:0]           buf_ch_q [2];
    logic [TW-1:0]           buf_ch_d [2];
    logic [1:0]              buf_cnt_q, buf_cnt_d;
    logic                    err_q, err_d;

    logic [CHANNELS_CNT-1:0] elig;
    logic [TW-1:0]           pick, cand;
    logic                    found;
    int                      idx;
    logic                    pop, credit_ok, rd_ok, leave;
    logic [1:0]              cnt_after_pop;

    // Pick the first eligible channel starting at rr_ptr (or at 0 in strict priority mode).
    always_comb begin
        elig  = i_en_channels & ~i_empty_channels;
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < CHANNELS_CNT; i++) begin
`ifdef FIFO_RDARBITER_STRICT_PRIORITY_EN
            idx = i;
`else
            idx = int'(rr_ptr_q) + i;
            idx = idx >= CHANNELS_CNT ? idx - CHANNELS_CNT : idx;
`endif
            cand = TW'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Grant FSM, read issue under the 2-word credit, return capture into the output buffer, sticky error.
    always_comb begin
        pop              = buf_cnt_q != 2'd0 && i_ready;
        credit_ok        = ({1'b0, buf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2;
        rd_ok            = state_q == BURST && !i_empty_channels[grant_q] && i_en_channels[grant_q] && credit_ok;
        leave            = (rd_ok && BW'(burst_cnt_q + 1'b1) == BMAX) || i_empty_channels[grant_q] || !i_en_channels[grant_q];
        o_rd_en_channels = rd_ok ? ONE << grant_q : '0;
        state_d          = state_q;
        grant_d          = grant_q;
        burst_cnt_d      = burst_cnt_q;
        rr_ptr_d         = rr_ptr_q;
        if (state_q == IDLE && found) begin
            state_d     = BURST;
            grant_d     = pick;
            burst_cnt_d = '0;
        end
        if (state_q == BURST) begin
            burst_cnt_d = rd_ok ? BW'(burst_cnt_q + 1'b1) : burst_cnt_q;
            state_d     = leave ? IDLE : BURST;
            rr_ptr_d    = leave ? (grant_q == LAST ? '0 : grant_q + 1'b1) : rr_ptr_q;
        end
`ifdef FIFO_RDARBITER_STRICT_PRIORITY_EN
        rr_ptr_d = '0;
`endif
        inflight_d    = rd_ok;
        tag_d         = rd_ok ? grant_q : tag_q;
        err_d         = err_q | (|(i_rd_valid_channels & ~(inflight_q ? ONE << tag_q : '0)));
        buf_data_d    = buf_data_q;
        buf_ch_d      = buf_ch_q;
        cnt_after_pop = buf_cnt_q - {1'b0, pop};
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_ch_d[0]   = buf_ch_q[1];
        end
        if (inflight_q) begin
            buf_data_d[cnt_after_pop[0]] = i_rd_data_channels[tag_q*CHANNEL_WIDTH +: CHANNEL_WIDTH];
            buf_ch_d[cnt_after_pop[0]]   = tag_q;
        end
        buf_cnt_d = cnt_after_pop + {1'b0, inflight_q};
    end

    // State registers; an asynchronous reset drops anything in flight or buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
            buf_data_q  <= '{default: '0};
            buf_ch_q    <= '{default: '0};
            buf_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            buf_data_q  <= buf_data_d;
            buf_ch_q    <= buf_ch_d;
            buf_cnt_q   <= buf_cnt_d;
            err_q       <= err_d;
        end
    end

    assign o_valid          = buf_cnt_q != 2'd0;
    assign o_data           = buf_data_q[0];
    assign o_channel        = buf_ch_q[0];
    assign o_busy           = state_q != IDLE || inflight_q || o_valid;
    assign o_err_unexpected = err_q;
endmodule

// File: doc/fifo_rdarbiter.md
# fifo_rdarbiter

Read-side scheduler for the multichannel FIFO. It drains the per-channel FIFOs into one tagged output stream, with round-robin channel selection and bounded bursts. It drives the FIFO's per-channel read enables and takes back the FIFO's read valid/data. A 2-entry output buffer gives the downstream consumer ready/valid backpressure without losing words.

## Interface
- CHANNEL_WIDTH, 32, data word width
- CHANNELS_CNT, 3, number of FIFO channels (≥2)
- BURST_MAX, 4, maximum reads issued per grant (≥1)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_en_channels  in  CHANNELS_CNT  per-channel arbitration mask (1 = eligible)
- i_empty_channels  in  CHANNELS_CNT  FIFO empty flags
- o_rd_en_channels  out  CHANNELS_CNT  FIFO read enables, one-hot or zero
- i_rd_valid_channels  in  CHANNELS_CNT  FIFO read valids
- i_rd_data_channels  in  CHANNELS_CNT×CHANNEL_WIDTH  FIFO read data, packed
- o_valid  out  1  output word valid
- o_data  out  CHANNEL_WIDTH  output word
- o_channel  out  $clog2(CHANNELS_CNT)  source channel of o_data
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_busy  out  1  state ≠ IDLE, or a read is in flight, or the buffer is non-empty
- o_err_unexpected  out  1  sticky error: read valid seen with no read in flight

## Operation
- FIFO contract:
  - Data and valid return exactly 1 cycle after rd_en is sampled.
  - The empty flag reflects a read by the cycle after that read.
  - Gating reads on !empty is therefore sufficient.
- State IDLE:
  - Eligible set = i_en_channels & ~i_empty_channels.
  - If the set is non-empty, pick the first eligible channel at or after rr_ptr, with modulo wrap.
  - Register the pick as grant, clear burst_cnt, move to BURST.
  - No read is issued in IDLE.
- State BURST: assert o_rd_en_channels[grant] when all of these hold:
  - !i_empty_channels[grant]
  - i_en_channels[grant]
  - credit ok: buf_cnt + inflight − (o_valid && i_ready) < 2
- Each issued read increments burst_cnt and sets inflight, with the channel tag piped alongside.
- Leave BURST to IDLE in any of these cases:
  - the read issued this cycle makes burst_cnt == BURST_MAX;
  - the granted channel is empty or masked;
  - on that exit, rr_ptr ← grant+1, wrapping at CHANNELS_CNT.
- A credit stall alone holds BURST and does not end the grant.
- Return path:
  - When inflight is set, capture i_rd_data_channels[tag] and the tag into the 2-entry buffer.
  - Push and pop in the same cycle keep buf_cnt unchanged.
  - Output order equals read-issue order.
- Errors:
  - Any i_rd_valid_channels bit set while inflight == 0, or set on a channel other than the tag, sets o_err_unexpected.
  - The flag clears only on reset.
  - Unexpected data is discarded.
- Widths:
  - burst_cnt is $clog2(BURST_MAX+1) bits.
  - buf_cnt is 2 bits, 0..2 and never 3.

## Timing
- Reset (asynchronous, any cycle):
  - state = IDLE, rr_ptr = 0.
  - o_rd_en_channels = 0, o_valid = 0, o_data = 0, o_channel = 0.
  - o_busy = 0, o_err_unexpected = 0, buffer and inflight cleared.
  - Data in flight at reset is dropped. The FIFO is reset alongside, so no stale valid appears.
- Latency: empty→non-empty at cycle t (while IDLE):
  - grant at t+1;
  - rd_en at t+1, issued from BURST;
  - o_valid at t+3.
- Throughput: with i_ready held high, one word per cycle within a burst, plus one idle cycle per grant change.
- o_valid/o_data/o_channel stay stable while o_valid && !i_ready.
- Simultaneous pop and return with buf_cnt = 2 cannot occur, because the credit rule prevents it.
- Mask drop mid-burst: the in-flight read still completes and is delivered.

## Configuration
- FIFO_RDARBITER_STRICT_PRIORITY_EN:
  - Defined: IDLE always picks the lowest-index eligible channel, and rr_ptr is unused (held 0).
  - Undefined: round-robin as described above.
  - Burst, credit and error logic are identical in both modes.

## Test plan
- Single channel, 1 word: channel 1 holds 0xA5A5_0001, i_ready=1 → exactly one rd_en[1], o_data=0xA5A5_0001, o_channel=1, o_valid 3 cycles after non-empty, then back to IDLE.
- Round-robin: all 3 channels hold 10 words, BURST_MAX=4 → channel order 0,0,0,0,1,1,1,1,2,2,2,2,0,…; no word lost or duplicated.
- Backpressure: i_ready low for 5 cycles mid-burst → at most 2 words buffered, o_data held stable, no rd_en while credit = 0, delivery in order once i_ready rises.
- Short channel: channel 2 holds 2 words, BURST_MAX=4 → 2 reads, early exit, rr_ptr=0 next.
- Error and reset: a spurious i_rd_valid_channels[0] while idle sets o_err_unexpected=1; then rst_n low mid-burst → all outputs 0 asynchronously, sticky flag cleared.
- With FIFO_RDARBITER_STRICT_PRIORITY_EN defined and channels 0 and 2 continuously non-empty → channel 2 is never granted.
